// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : controller states (IDLE, CALC, DONE)
//   DIV_N       : default divisor/remainder width
//   cnt_width() : width of the step counter, $clog2(2N+1)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_N = 16;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits.
//   r      : current partial remainder (N+1 bits)
//   q_msb  : dividend/quotient bit being shifted in
//   d      : divisor
//   r_next : partial remainder after the step
//   q_bit  : quotient bit produced by the step
module div_restore_step #(
  parameter int N = 16
) (
  input  logic [N:0]   r,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  localparam int RW = N + 1;
  localparam int SW = N + 2;

  // One extra bit over the stored remainder keeps the compare exact even if
  // r[N] were ever set; in normal operation it stays zero.
  logic [N+1:0] shifted;
  logic [N+1:0] d_ext;

  assign shifted = {r, q_msb};
  assign d_ext   = {2'b00, d};
  assign q_bit   = (shifted >= d_ext);
  assign r_next  = q_bit ? RW'(SW'(shifted - d_ext)) : shifted[N:0];

endmodule

// File: rtl/seq_divider_32x16.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, valid/ready handshakes on both sides.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operands valid
//   in_ready   : idle, operands can be accepted
//   dividend   : 2N-bit numerator
//   divisor    : N-bit denominator
//   out_valid  : result valid
//   out_ready  : consumer accepts result
//   quotient   : 2N-bit quotient
//   remainder  : N-bit remainder
//   div_zero   : divisor was zero (only with SEQ_DIVIDER_DIV_ZERO_EN)
//
// Build option SEQ_DIVIDER_DIV_ZERO_EN: a zero divisor bypasses CALC and
// produces the all-ones / dividend-low result immediately, flagged by div_zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring step per cycle, count runs 2N down to 1
// DONE  | result presented, held until out_ready
module seq_divider_32x16
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  output logic           div_zero,
`endif
  output logic [N-1:0]   remainder
);

  localparam int CW = cnt_width(N);

  div_state_e      state_q;
  div_state_e      state_d;
  logic [2*N-1:0]  q_reg;
  logic [N:0]      r_reg;
  logic [N-1:0]    d_reg;
  logic [CW-1:0]   cnt;
  logic [N:0]      r_next;
  logic            q_bit;
  logic            accept;
  logic            last_step;

  div_restore_step #(.N(N)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[2*N-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so in_ready stays low while reset is held.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          if (divisor == '0) state_d = DONE;
          else               state_d = CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            q_reg <= dividend;
            r_reg <= '0;
            d_reg <= divisor;
            cnt   <= CW'(2 * N);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            // Same values the full algorithm would reach for D = 0.
            if (divisor == '0) begin
              q_reg <= '1;
              r_reg <= {1'b0, dividend[N-1:0]};
              cnt   <= '0;
            end
`endif
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= {q_reg[2*N-2:0], q_bit};
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  logic dz_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dz_reg <= 1'b0;
    end else if (accept) begin
      dz_reg <= (divisor == '0);
    end else if (out_valid && out_ready) begin
      dz_reg <= 1'b0;
    end
  end

  assign div_zero = dz_reg;
`endif

  assign quotient  = q_reg;
  assign remainder = r_reg[N-1:0];

endmodule

// File: tb/tb_seq_divider_32x16.sv
module tb_seq_divider_32x16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        dz;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  localparam bit DZ_EN = 1'b1;
  logic div_zero;
  assign dz = div_zero;
`else
  localparam bit DZ_EN = 1'b0;
  assign dz = 1'b0;
`endif

  seq_divider_32x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    .div_zero  (div_zero),
`endif
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [31:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair; returns the number of edges after the accept
  // edge until out_valid is seen (bounded).
  task automatic start_div(input logic [31:0] a, input logic [15:0] b, output int lat);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int exp_lat;
    exp_lat = (DZ_EN && v.dvs == 16'd0) ? 0 : 32;
    start_div(v.dvd, v.dvs, lat);
    chk("latency", lat, exp_lat);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("quotient", quotient, v.q);
    chk("remainder", {16'd0, remainder}, {16'd0, v.r});
    if (DZ_EN) chk("div_zero", {31'd0, dz}, {31'd0, v.dvs == 16'd0});
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    if (DZ_EN) chk("div_zero_after_hs", {31'd0, dz}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{32'd61440,      16'd60,   32'd1024,      16'd0};
    vecs[1] = '{32'd3932100,    16'd60,   32'd65535,     16'd0};
    vecs[2] = '{32'd500000,     16'd1000, 32'd500,       16'd0};
    vecs[3] = '{32'hFFFF_FFFF,  16'd7,    32'd613566756, 16'd3};
    vecs[4] = '{32'd100,        16'd7,    32'd14,        16'd2};
    vecs[5] = '{32'h1234_5678,  16'd0,    32'hFFFF_FFFF, 16'h5678};
    vecs[6] = '{32'd7,          16'd7,    32'd1,         16'd0};
    vecs[7] = '{32'd6,          16'd7,    32'd0,         16'd6};
    vecs[8] = '{32'h0001_0000,  16'hFFFF, 32'd1,         16'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_div_zero", {31'd0, dz}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: result must hold, in_valid pulse ignored.
    out_ready = 1'b0;
    start_div(32'd100, 16'd7, lat);
    chk("bp_latency", lat, 32'd32);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dividend = 32'd999;
        divisor  = 16'd3;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_quotient", quotient, 32'd14);
      chk("bp_remainder", {16'd0, remainder}, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_vec(vecs[2]);

    // Reset mid-CALC discards the operation.
    dividend = 32'd61440;
    divisor  = 16'd60;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", {16'd0, remainder}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_release", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 32'd0);
    run_vec(vecs[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
